// File: rtl/vcmac_seq.sv
// vcmac_seq: job sequencer for the N-lane vector complex MAC.
// Streams LEN operand chunks out of the amplitude/gate buffers, aligns the
// MAC mult/acc enables to the 1-cycle buffer latency, then holds the result
// behind a valid/ready handshake together with a sticky overflow flag.
module vcmac_seq #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              abs_mode,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              w_en_mult,
  output logic              w_en_acc,
  output logic              acc,
  output logic              abs,
  input  logic              mac_overflow,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_overflow,
  output logic              len_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;      // index of the chunk being issued
  logic [LEN_W-1:0]   len_q, len_d;      // latched job length
  logic [ADDR_W-1:0]  addr_q, addr_d;    // address of the chunk being issued
  logic               abs_q, abs_d;      // latched magnitude mode
  logic               v1_q, v1_d;        // operands at MAC inputs (mult stage)
  logic               f1_q, f1_d;        // mult-stage chunk is chunk 0
  logic               v2_q, v2_d;        // product ready for accumulation
  logic               f2_q, f2_d;        // acc-stage chunk is chunk 0
  logic               ovf_win_q, ovf_win_d; // previous cycle was an acc cycle
  logic               sticky_q, sticky_d;   // job overflow seen
  logic               len_err_q, len_err_d;

  logic               issue;
  logic               last_chunk;

  // State register and all datapath flops; reset abandons any in-flight job
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      abs_q     <= 1'b0;
      v1_q      <= 1'b0;
      f1_q      <= 1'b0;
      v2_q      <= 1'b0;
      f2_q      <= 1'b0;
      ovf_win_q <= 1'b0;
      sticky_q  <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      abs_q     <= abs_d;
      v1_q      <= v1_d;
      f1_q      <= f1_d;
      v2_q      <= v2_d;
      f2_q      <= f2_d;
      ovf_win_q <= ovf_win_d;
      sticky_q  <= sticky_d;
      len_err_q <= len_err_d;
    end
  end

  // Issue-stage decode shared by the pipeline and the FSM
  always_comb begin
    issue      = (state_q == ISSUE);
    // Counter stays LEN_W bits; comparing against len-1 lets len = 2^LEN_W-1
    // finish without the counter ever wrapping.
    last_chunk = (cnt_q == (len_q - LEN_W'(1)));
  end

  // Next-state logic, counters, alignment shift register and sticky overflow
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    addr_d    = addr_q;
    abs_d     = abs_q;
    sticky_d  = sticky_q;
    len_err_d = 1'b0;

    // Two-stage valid/first shift register: issue at t -> mult at t+1 -> acc at t+2
    v1_d      = issue;
    f1_d      = issue && (cnt_q == '0);
    v2_d      = v1_q;
    f2_d      = f1_q;
    ovf_win_d = v2_q;

    // MAC overflow reports one cycle after the accumulation that caused it
    if (ovf_win_q && mac_overflow) begin
      sticky_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            len_d    = len;
            addr_d   = base_addr;
            abs_d    = abs_mode;
            cnt_d    = '0;
            sticky_d = 1'b0;
            state_d  = ISSUE;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        cnt_d  = cnt_q + LEN_W'(1);
        addr_d = addr_q + ADDR_W'(1);
        if (last_chunk) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Last acc cycle: acc stage busy and nothing behind it in mult stage
        if (v2_q && !v1_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state so reset clears them at once
  always_comb begin
    busy      = (state_q != IDLE);
    rd_en     = issue;
    rd_addr   = issue ? addr_q : '0;
    w_en_mult = v1_q;
    w_en_acc  = v2_q;
    acc       = v2_q && !f2_q;
    abs       = abs_q && (state_q != IDLE);
    res_valid = (state_q == DONE);
    // Include the overflow report for the final accumulation, which lands in
    // the first DONE cycle, so res_overflow is correct from res_valid onward.
    res_overflow = (state_q == DONE) && (sticky_q || (ovf_win_q && mac_overflow));
    len_err   = len_err_q;
  end

endmodule

// File: tb/tb_vcmac_seq.sv
// Self-checking bench for vcmac_seq: per-job scoreboard of read, mult,
// acc and result events plus per-cycle busy/abs/res_valid expectations.
module tb_vcmac_seq;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len;
  logic              abs_mode;
  logic              busy;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              w_en_mult;
  logic              w_en_acc;
  logic              acc;
  logic              abs;
  logic              mac_overflow;
  logic              res_valid;
  logic              res_ready;
  logic              res_overflow;
  logic              len_err;

  always #5 clk = ~clk;

  vcmac_seq #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .abs_mode(abs_mode), .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr),
    .w_en_mult(w_en_mult), .w_en_acc(w_en_acc), .acc(acc), .abs(abs),
    .mac_overflow(mac_overflow), .res_valid(res_valid), .res_ready(res_ready),
    .res_overflow(res_overflow), .len_err(len_err)
  );

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic              bitv;
  } ev_t;

  ev_t rdq[$];
  ev_t mq[$];
  ev_t aq[$];
  ev_t rq[$];

  int errors = 0;
  int checks = 0;

  // One job: accept in cycle 0, stall the result for 'stall' cycles, handshake.
  task automatic run_job(input logic [ADDR_W-1:0] base, input int n, input logic absm,
                         input int ovf_idx, input int stall, input logic exp_ovf);
    ev_t               e;
    logic [ADDR_W-1:0] a;
    bit                rv_seen;
    int                last;
    last = n + 3 + stall;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL job_idle_busy: got %b exp 0", busy);
    end
    start = 1'b1; base_addr = base; len = LEN_W'(n); abs_mode = absm;
    res_ready = 1'b0; mac_overflow = 1'b0;
    for (int k = 0; k < n; k++) begin
      a = base + ADDR_W'(k);
      rdq.push_back('{1 + k, a, 1'b0});
      mq.push_back('{2 + k, '0, 1'b0});
      aq.push_back('{3 + k, '0, (k != 0)});
    end
    rq.push_back('{n + 3, '0, exp_ovf});
    rv_seen = 1'b0;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (rd_en) begin
        checks++;
        if (rdq.size() == 0) begin
          errors++; $display("FAIL rd_extra: cycle %0d addr %0h exp none", c, rd_addr);
        end else begin
          e = rdq.pop_front();
          if (e.cyc != c || rd_addr !== e.addr) begin
            errors++;
            $display("FAIL rd: got cyc %0d addr %0h exp cyc %0d addr %0h", c, rd_addr, e.cyc, e.addr);
          end
        end
      end
      if (w_en_mult) begin
        checks++;
        if (mq.size() == 0) begin
          errors++; $display("FAIL mult_extra: cycle %0d exp none", c);
        end else begin
          e = mq.pop_front();
          if (e.cyc != c) begin
            errors++; $display("FAIL mult: got cyc %0d exp cyc %0d", c, e.cyc);
          end
        end
      end
      if (w_en_acc) begin
        checks++;
        if (aq.size() == 0) begin
          errors++; $display("FAIL acc_extra: cycle %0d exp none", c);
        end else begin
          e = aq.pop_front();
          if (e.cyc != c || acc !== e.bitv) begin
            errors++;
            $display("FAIL acc: got cyc %0d acc %b exp cyc %0d acc %b", c, acc, e.cyc, e.bitv);
          end
        end
      end
      if (res_valid === 1'b1 && !rv_seen) begin
        rv_seen = 1'b1;
        checks++;
        if (rq.size() == 0) begin
          errors++; $display("FAIL res_extra: cycle %0d exp none", c);
        end else begin
          e = rq.pop_front();
          if (e.cyc != c || res_overflow !== e.bitv) begin
            errors++;
            $display("FAIL res: got cyc %0d ovf %b exp cyc %0d ovf %b", c, res_overflow, e.cyc, e.bitv);
          end
        end
      end else if (res_valid === 1'b1) begin
        checks++;
        if (res_overflow !== exp_ovf) begin
          errors++; $display("FAIL res_ovf_hold: cycle %0d got %b exp %b", c, res_overflow, exp_ovf);
        end
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL busy: cycle %0d got %b exp 1", c, busy);
      end
      checks++;
      if (abs !== absm) begin
        errors++; $display("FAIL abs: cycle %0d got %b exp %b", c, abs, absm);
      end
      checks++;
      if (res_valid !== (c >= n + 3)) begin
        errors++; $display("FAIL res_valid: cycle %0d got %b exp %b", c, res_valid, (c >= n + 3));
      end
      start        = (stall > 0) && (c >= n + 3) && (c % 2 == 0);
      mac_overflow = (ovf_idx >= 0) && (c == 4 + ovf_idx);
      res_ready    = (c == last);
    end
    checks++;
    if (rdq.size() + mq.size() + aq.size() + rq.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d pending events exp 0", rdq.size() + mq.size() + aq.size() + rq.size());
    end
  endtask

  task automatic finish_idle();
    @(negedge clk);
    start = 1'b0; res_ready = 1'b0; mac_overflow = 1'b0;
    checks++;
    if ({busy, res_valid, abs, rd_en, w_en_mult, w_en_acc} !== 6'b0) begin
      errors++;
      $display("FAIL post_idle: got %b exp 000000", {busy, res_valid, abs, rd_en, w_en_mult, w_en_acc});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; abs_mode = 1'b0;
    mac_overflow = 1'b0; res_ready = 1'b0;
    #1;
    checks++;
    if ({busy, rd_en, rd_addr, w_en_mult, w_en_acc, acc, abs, res_valid, res_overflow, len_err} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero exp all zero");
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    run_job(10'd5, 1, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_wrap();
    run_job(10'h3FE, 4, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_job(10'h020, 2, 1'b0, -1, 10, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_job(10'h100, 3, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_overflow();
    run_job(10'h040, 3, 1'b0, 1, 0, 1'b1);
    run_job(10'h050, 3, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_len_zero();
    @(negedge clk);
    start = 1'b1; len = '0; base_addr = 10'h077; res_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (len_err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL len_err_pulse: got err %b busy %b exp err 1 busy 0", len_err, busy);
    end
    @(negedge clk);
    checks++;
    if (len_err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL len_err_clear: got err %b busy %b exp err 0 busy 0", len_err, busy);
    end
  endtask

  task automatic test_reset_midjob();
    @(negedge clk);
    start = 1'b1; base_addr = 10'h010; len = LEN_W'(8); abs_mode = 1'b1; res_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (rd_en !== 1'b1 || rd_addr !== 10'h013) begin
      errors++; $display("FAIL midjob_issue: got rd_en %b addr %0h exp 1 13", rd_en, rd_addr);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy, rd_en, rd_addr, w_en_mult, w_en_acc, acc, abs, res_valid, res_overflow, len_err} !== '0) begin
      errors++; $display("FAIL async_reset: got nonzero outputs exp all zero");
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_quiet: cycle %0d got rv %b busy %b rd %b exp 0 0 0", c, res_valid, busy, rd_en);
      end
    end
    run_job(10'h200, 5, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_abs();
    run_job(10'h300, 2, 1'b1, -1, 2, 1'b0);
    finish_idle();
  endtask

  task automatic test_max_len();
    run_job(10'h201, 1023, 1'b0, -1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_len_zero();
    test_reset_midjob();
    test_abs();
    test_max_len();
    finish_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vcmac_seq.md
Name: vcmac_seq

Overview:
- Control sequencer directly upstream of the N-lane vector complex MAC.
- Per job: streams LEN operand chunks from the amplitude/gate buffers (1-cycle read latency), and drives the MAC's mult-enable, acc-enable, acc and abs controls with correct pipeline alignment.
- Waits for the final accumulation, then raises a result-valid handshake, so the MAC's S_r/S_i outputs and a sticky overflow flag can be consumed downstream.

Parameters:
- ADDR_W, 10, operand buffer address width.
- LEN_W, 10, width of the chunk-count field; max job length is 2^LEN_W-1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  job request; accepted only in IDLE
- base_addr  in  ADDR_W  first chunk address, sampled at accept
- len  in  LEN_W  number of chunks, sampled at accept
- abs_mode  in  1  magnitude mode for this job, sampled at accept
- busy  out  1  high from accept until the result handshake completes
- rd_en  out  1  operand buffer read strobe; data arrives the next cycle
- rd_addr  out  ADDR_W  operand buffer address
- w_en_mult  out  1  MAC product-register enable
- w_en_acc  out  1  MAC accumulator enable
- acc  out  1  0 = load product, 1 = add product to accumulator
- abs  out  1  MAC magnitude mode
- mac_overflow  in  1  MAC overflow (OR of lanes)
- res_valid  out  1  MAC S_r/S_i hold the final job result
- res_ready  in  1  downstream accepts the result
- res_overflow  out  1  sticky overflow for the job; meaningful while res_valid
- len_err  out  1  one-cycle pulse when start is given with len=0 in IDLE

Behaviour:
- Reset (async, any state): state=IDLE; every output 0; all counters, pipeline valid bits and sticky flags 0. An in-flight job is abandoned and no res_valid is produced for it.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 and len!=0: latch base_addr, len, abs_mode; clear the sticky overflow; go to ISSUE; busy=1 from the next cycle.
  - start=1 and len=0: pulse len_err for 1 cycle; remain in IDLE.
- ISSUE: one chunk per cycle, no bubbles.
  - Chunk k (k = 0..len-1) is issued in ISSUE cycle k with rd_en=1 and rd_addr = base + k. Address wraps modulo 2^ADDR_W.
  - After the issue with k = len-1, go to DRAIN.
- Pipeline alignment, for a chunk issued at cycle t:
  - t+1: w_en_mult=1 (operands valid at the MAC inputs).
  - t+2: w_en_acc=1, with acc=0 for chunk 0 and acc=1 for every later chunk.
  - Implement with a 2-stage valid/first shift register, not with state decode.
  - abs = latched abs_mode from accept until return to IDLE; 0 in IDLE.
- DRAIN: wait until the last chunk's w_en_acc cycle has passed. The MAC output is valid the cycle after that cycle. Then go to DONE.
  - Accept-to-res_valid latency = len + 3 cycles.
- Sticky overflow: set when mac_overflow=1 in the cycle following any w_en_acc=1 cycle of the job.
- DONE:
  - res_valid=1 and res_overflow=sticky, both held stable.
  - w_en_mult and w_en_acc are 0, so the MAC holds S.
  - When res_valid and res_ready are both 1: go to IDLE; busy and res_valid drop the next cycle.
  - res_ready=0 stalls indefinitely.
- start is ignored outside IDLE, including in DONE. A start in the same cycle as the DONE handshake is ignored; the earliest accept is the following cycle.
- res_ready outside DONE has no effect.
- len = 2^LEN_W-1 is legal; the chunk counter must not overflow. The counter must be LEN_W bits, compared against len-1.

Test Plan:
- Single chunk:
  - Stimulus: base=5, len=1, abs=0, accepted at cycle 0; res_ready=1.
  - Required: rd_en@1 addr 5; w_en_mult@2; w_en_acc@3 with acc=0; res_valid@4; busy drops @5.
- Four chunks:
  - Stimulus: base=0x3FE, len=4 (ADDR_W=10).
  - Required: addrs 0x3FE, 0x3FF, 0x000, 0x001 on consecutive cycles; acc pattern 0,1,1,1; res_valid exactly len+3=7 cycles after accept.
- Back-pressure:
  - Stimulus: res_ready=0 for 10 cycles in DONE; start pulses during that window.
  - Required: res_valid stays high; no rd_en, w_en_mult or w_en_acc; starts ignored. After res_ready=1, a new start the following cycle is accepted.
- Overflow:
  - Stimulus: len=3; mac_overflow=1 for one cycle after the 2nd acc only.
  - Required: res_overflow=1. A following clean job reports res_overflow=0.
- len=0 and reset:
  - Stimulus: start with len=0.
  - Required: len_err for 1 cycle, busy stays 0.
  - Stimulus: len=8 job, assert rst during ISSUE cycle 3.
  - Required: all outputs 0 immediately (asynchronously); no res_valid afterwards; the next job runs normally.
- abs propagation:
  - Stimulus: abs_mode=1 job with len=2.
  - Required: abs=1 from accept through the DONE handshake, 0 in IDLE.
